// File: rtl/sine_pkg.sv
// Shared types and helpers for the two-channel quarter-wave sine ROM scheduler.
// Widths live here so the fold/reconstruct helpers and the datapath stay in step.
package sine_pkg;

   localparam int ACC_W  = 16;
   localparam int LUT_AW = 7;
   localparam int DATA_W = 10;
   localparam int TOP_W  = LUT_AW + 2;

   localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, FETCH0, FETCH1, CAPT1} state_e;

   typedef struct packed {
      logic              sign;
      logic [LUT_AW-1:0] addr;
   } fold_t;

   // ph_top is the quadrant plus table index taken from the accumulator MSBs
   function automatic fold_t fold(input logic [TOP_W-1:0] ph_top);
      fold_t             f;
      logic [1:0]        q;
      logic [LUT_AW-1:0] idx;
      q      = ph_top[TOP_W-1:TOP_W-2];
      idx    = ph_top[LUT_AW-1:0];
      f.addr = q[0] ? ~idx : idx;
      f.sign = q[1];
      return f;
   endfunction

   // A 9-bit magnitude around MID never leaves 1..1023, so no clamp
   function automatic logic [DATA_W-1:0] reconstruct(input logic [DATA_W-2:0] mag,
                                                     input logic            sign);
      return sign ? (MID - {1'b0, mag}) : (MID + {1'b0, mag});
   endfunction

endpackage

// File: rtl/sine_phase_acc.sv
// Per-channel phase accumulator; phase_o is the value before the pending step.
module sine_phase_acc #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic [W-1:0] step_i,
   input  logic         advance_i,
   output logic [W-1:0] phase_o
);

   logic [W-1:0] acc_q;
   logic [W-1:0] acc_d;

   // Wraps modulo 2^W by plain truncation
   assign acc_d   = advance_i ? (acc_q + step_i) : acc_q;
   assign phase_o = acc_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) acc_q <= '0;
      else         acc_q <= acc_d;
   end

endmodule

// File: rtl/sine_rom_scheduler.sv
// Shares one registered quarter-wave ROM between two tone channels, issuing
// both reads back-to-back per sample tick and rebuilding full-scale samples.
module sine_rom_scheduler
   import sine_pkg::*;
(
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              en_i,
   input  logic              tick_i,
   input  logic [ACC_W-1:0]  step0_i,
   input  logic [ACC_W-1:0]  step1_i,
   output logic [LUT_AW-1:0] rom_addr_o,
   input  logic [DATA_W-2:0] rom_data_i,
   output logic [DATA_W-1:0] sample0_o,
   output logic [DATA_W-1:0] sample1_o,
   output logic [1:0]        valid_o,
   output logic              busy_o,
   output logic              overrun_o
);

   state_e            state_q;
   logic [LUT_AW-1:0] rom_addr_q;
   logic [DATA_W-1:0] sample0_q, sample1_q;
   logic [1:0]        valid_q;
   logic              overrun_q;
   logic              sign0_q, sign1_q;
   logic [TOP_W-1:0]  ph1_top_q;

   logic [ACC_W-1:0]  ph0, ph1;
   logic              accept;
   fold_t             f0_d, f1_d;
   logic              unused_ph;

   assign accept = (state_q == IDLE) && en_i && tick_i;

   sine_phase_acc #(.W(ACC_W)) u_acc0 (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .step_i   (step0_i),
      .advance_i(accept),
      .phase_o  (ph0)
   );

   sine_phase_acc #(.W(ACC_W)) u_acc1 (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .step_i   (step1_i),
      .advance_i(accept),
      .phase_o  (ph1)
   );

   assign f0_d = fold(ph0[ACC_W-1 -: TOP_W]);
   // Channel 1 uses the snapshot taken at accept, since acc1 has already stepped
   assign f1_d = fold(ph1_top_q);

   // Fractional phase bits only matter to the accumulators themselves
   assign unused_ph = ^{ph0[ACC_W-TOP_W-1:0], ph1[ACC_W-TOP_W-1:0]};

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         rom_addr_q <= '0;
         sample0_q  <= MID;
         sample1_q  <= MID;
         valid_q    <= '0;
         overrun_q  <= 1'b0;
         sign0_q    <= 1'b0;
         sign1_q    <= 1'b0;
         ph1_top_q  <= '0;
      end else begin
         valid_q <= '0;
         if (tick_i && (state_q != IDLE)) overrun_q <= 1'b1;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  state_q    <= FETCH0;
                  rom_addr_q <= f0_d.addr;
                  sign0_q    <= f0_d.sign;
                  ph1_top_q  <= ph1[ACC_W-1 -: TOP_W];
               end
            end
            FETCH0: begin
               state_q    <= FETCH1;
               rom_addr_q <= f1_d.addr;
               sign1_q    <= f1_d.sign;
            end
            FETCH1: begin
               state_q   <= CAPT1;
               sample0_q <= reconstruct(rom_data_i, sign0_q);
               valid_q   <= 2'b01;
            end
            CAPT1: begin
               state_q   <= IDLE;
               sample1_q <= reconstruct(rom_data_i, sign1_q);
               valid_q   <= 2'b10;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rom_addr_o = rom_addr_q;
   assign sample0_o  = sample0_q;
   assign sample1_o  = sample1_q;
   assign valid_o    = valid_q;
   assign busy_o     = (state_q != IDLE);
   assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_sine_rom_scheduler.sv
// Bench for sine_rom_scheduler: vector table plus hand sequences, with a
// per-channel scoreboard popped on each valid pulse. ROM model: data = 4*addr.
module tb_sine_rom_scheduler;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        en_i;
   logic        tick_i;
   logic [15:0] step0_i, step1_i;
   logic [6:0]  rom_addr_o;
   logic [8:0]  rom_data_i;
   logic [9:0]  sample0_o, sample1_o;
   logic [1:0]  valid_o;
   logic        busy_o;
   logic        overrun_o;

   sine_rom_scheduler dut (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .en_i      (en_i),
      .tick_i    (tick_i),
      .step0_i   (step0_i),
      .step1_i   (step1_i),
      .rom_addr_o(rom_addr_o),
      .rom_data_i(rom_data_i),
      .sample0_o (sample0_o),
      .sample1_o (sample1_o),
      .valid_o   (valid_o),
      .busy_o    (busy_o),
      .overrun_o (overrun_o)
   );

   always #5 clk_i = ~clk_i;

   // One-cycle registered ROM
   always @(posedge clk_i) rom_data_i <= {rom_addr_o, 2'b00};

   int tests = 0;
   int fails = 0;
   int vcnt0 = 0;
   int vcnt1 = 0;
   int q0[$];
   int q1[$];

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   always @(negedge clk_i) begin
      if (!reset_i) begin
         if (valid_o[0]) begin
            vcnt0++;
            if (q0.size() == 0) chk("unexpected valid0", 1, 0);
            else                chk("sample0", int'(sample0_o), q0.pop_front());
         end
         if (valid_o[1]) begin
            vcnt1++;
            if (q1.size() == 0) chk("unexpected valid1", 1, 0);
            else                chk("sample1", int'(sample1_o), q1.pop_front());
         end
      end
   end

   typedef struct {
      bit          rst_before;
      int          gap;
      logic [15:0] step0;
      logic [15:0] step1;
      int          exp_s0;
      int          exp_s1;
      int          exp_addr;
   } vec_t;

   vec_t vecs[16];

   function automatic vec_t mk(bit r, int g, logic [15:0] s0, logic [15:0] s1,
                               int e0, int e1, int ea);
      vec_t v;
      v.rst_before = r; v.gap = g; v.step0 = s0; v.step1 = s1;
      v.exp_s0 = e0; v.exp_s1 = e1; v.exp_addr = ea;
      return v;
   endfunction

   task automatic do_reset();
      reset_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1 reset_i = 1'b0;
   endtask

   // Starts #1 after a posedge; the next posedge accepts the tick
   task automatic issue(input int gap, input int exp_addr);
      tick_i = 1'b1;
      @(posedge clk_i);
      #1 tick_i = 1'b0;
      chk("rom_addr after accept", int'(rom_addr_o), exp_addr);
      chk("busy after accept", int'(busy_o), 1);
      repeat (gap - 1) @(posedge clk_i);
      #1;
   endtask

   initial begin
      // Quarter steps on channel 0, ticks every 8
      vecs[0]  = mk(1, 8, 16'h4000, 16'h0000,  512, 512,   0);
      vecs[1]  = mk(0, 8, 16'h4000, 16'h0000, 1020, 512, 127);
      vecs[2]  = mk(0, 8, 16'h4000, 16'h0000,  512, 512,   0);
      vecs[3]  = mk(0, 8, 16'h4000, 16'h0000,    4, 512, 127);
      vecs[4]  = mk(0, 8, 16'h4000, 16'h0000,  512, 512,   0);
      // Channel 1 independence
      vecs[5]  = mk(1, 8, 16'h0000, 16'h0080,  512, 512,   0);
      vecs[6]  = mk(0, 8, 16'h0000, 16'h0080,  512, 516,   0);
      vecs[7]  = mk(0, 8, 16'h0000, 16'h0080,  512, 520,   0);
      // Wrap, back-to-back every 4 cycles: q = 0,3,2,1,0,3,2,1
      vecs[8]  = mk(1, 4, 16'hC000, 16'h0000,  512, 512,   0);
      vecs[9]  = mk(0, 4, 16'hC000, 16'h0000,    4, 512, 127);
      vecs[10] = mk(0, 4, 16'hC000, 16'h0000,  512, 512,   0);
      vecs[11] = mk(0, 4, 16'hC000, 16'h0000, 1020, 512, 127);
      vecs[12] = mk(0, 4, 16'hC000, 16'h0000,  512, 512,   0);
      vecs[13] = mk(0, 4, 16'hC000, 16'h0000,    4, 512, 127);
      vecs[14] = mk(0, 4, 16'hC000, 16'h0000,  512, 512,   0);
      vecs[15] = mk(0, 4, 16'hC000, 16'h0000, 1020, 512, 127);

      reset_i = 1'b1; en_i = 1'b1; tick_i = 1'b0;
      step0_i = '0; step1_i = '0;
      repeat (2) @(posedge clk_i);
      #1 reset_i = 1'b0;
      chk("reset sample0", int'(sample0_o), 512);
      chk("reset sample1", int'(sample1_o), 512);
      chk("reset valid", int'(valid_o), 0);
      chk("reset busy", int'(busy_o), 0);
      chk("reset overrun", int'(overrun_o), 0);
      chk("reset rom_addr", int'(rom_addr_o), 0);

      foreach (vecs[i]) begin
         if (vecs[i].rst_before) begin
            repeat (4) @(posedge clk_i);
            #1 do_reset();
         end
         step0_i = vecs[i].step0;
         step1_i = vecs[i].step1;
         q0.push_back(vecs[i].exp_s0);
         q1.push_back(vecs[i].exp_s1);
         issue(vecs[i].gap, vecs[i].exp_addr);
         chk("overrun stays low", int'(overrun_o), 0);
      end
      repeat (6) @(posedge clk_i);
      #1;
      chk("valid0 count after table", vcnt0, 16);
      chk("valid1 count after table", vcnt1, 16);

      // Overrun: second tick one cycle after acceptance
      begin
         int c0, c1;
         do_reset();
         step0_i = 16'h4000; step1_i = 16'h0000;
         c0 = vcnt0; c1 = vcnt1;
         q0.push_back(512); q1.push_back(512);
         tick_i = 1'b1;
         @(posedge clk_i);
         #1;
         @(posedge clk_i);
         #1 tick_i = 1'b0;
         repeat (6) @(posedge clk_i);
         #1;
         chk("overrun set", int'(overrun_o), 1);
         chk("overrun one valid0", vcnt0 - c0, 1);
         chk("overrun one valid1", vcnt1 - c1, 1);
         q0.push_back(1020); q1.push_back(512);
         issue(8, 127);
         chk("overrun sticky", int'(overrun_o), 1);
      end

      // Enable gating: acc0 now sits at 0x8000
      begin
         int c0, bsy;
         en_i = 1'b0;
         c0 = vcnt0; bsy = 0;
         for (int k = 0; k < 4; k++) begin
            tick_i = 1'b1;
            @(posedge clk_i);
            #1 tick_i = 1'b0;
            for (int j = 0; j < 3; j++) begin
               if (busy_o) bsy++;
               @(posedge clk_i);
               #1;
            end
         end
         chk("en low busy never rises", bsy, 0);
         chk("en low no valid", vcnt0 - c0, 0);
         chk("en low sample0 held", int'(sample0_o), 1020);
         en_i = 1'b1;
         q0.push_back(512); q1.push_back(512);
         tick_i = 1'b1;
         @(posedge clk_i);
         #1 tick_i = 1'b0; en_i = 1'b0;
         chk("en drop rom_addr", int'(rom_addr_o), 0);
         repeat (6) @(posedge clk_i);
         #1;
         chk("en drop valid0 count", vcnt0 - c0, 1);
         chk("en drop valid1 count", vcnt1 - c0 - (vcnt1 - vcnt0), 1);
         tick_i = 1'b1;
         @(posedge clk_i);
         #1 tick_i = 1'b0;
         chk("en low later tick ignored", int'(busy_o), 0);
      end

      // Reset mid-sequence discards the partial sequence
      begin
         int c0, c1;
         en_i = 1'b1; step0_i = 16'h4000;
         c0 = vcnt0; c1 = vcnt1;
         tick_i = 1'b1;
         @(posedge clk_i);
         #1 tick_i = 1'b0;
         @(posedge clk_i);
         #1 reset_i = 1'b1;
         repeat (2) @(posedge clk_i);
         #1 reset_i = 1'b0;
         chk("midreset sample0", int'(sample0_o), 512);
         chk("midreset sample1", int'(sample1_o), 512);
         chk("midreset valid", int'(valid_o), 0);
         chk("midreset busy", int'(busy_o), 0);
         chk("midreset overrun", int'(overrun_o), 0);
         chk("midreset rom_addr", int'(rom_addr_o), 0);
         repeat (5) @(posedge clk_i);
         #1;
         chk("midreset no valid0", vcnt0 - c0, 0);
         chk("midreset no valid1", vcnt1 - c1, 0);
      end

      chk("scoreboard0 drained", q0.size(), 0);
      chk("scoreboard1 drained", q1.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sine_rom_scheduler.md
Name: sine_rom_scheduler

Overview:
- Time-multiplexes one synchronous quarter-wave sine ROM between two independent tone channels.
- Each channel has a phase accumulator. On each sample tick the block steps both accumulators, folds each phase into a ROM address plus sign, and issues the two reads back-to-back.
- It rebuilds each full-scale unsigned 10-bit sample and presents it with a valid pulse. Output feeds the DAC pin driver in top.

Parameters:
- ACC_W, 16: phase accumulator width; wraps modulo 2^ACC_W.
- LUT_AW, 7: ROM address width, giving a 128-entry quarter wave.
- DATA_W, 10: output sample width. ROM magnitude width is DATA_W-1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- en  in  1  enable; when low, ticks are ignored in IDLE
- tick  in  1  sample-rate strobe, one cycle wide
- step0  in  ACC_W  channel 0 phase increment, sampled at the accepting tick edge
- step1  in  ACC_W  channel 1 phase increment, sampled at the accepting tick edge
- rom_addr  out  LUT_AW  registered ROM address
- rom_data  in  DATA_W-1  ROM magnitude, valid one cycle after the ROM samples rom_addr
- sample0  out  DATA_W  channel 0 sample
- sample1  out  DATA_W  channel 1 sample
- valid  out  2  per-channel one-cycle pulse when the matching sample updates
- busy  out  1  high while state != IDLE
- overrun  out  1  sticky; set by a tick arriving while busy

Behaviour:
- Reset values: state IDLE; acc0=acc1=0; rom_addr=0; sample0=sample1=512 (MID = 2^(DATA_W-1)); valid=0; overrun=0; sign registers 0.
- Phase fold, with ph the accumulator value before the step:
  - q = ph[ACC_W-1:ACC_W-2]; idx = ph[ACC_W-3:ACC_W-2-LUT_AW].
  - Address: q even -> idx; q odd -> ~idx.
  - Sign: negative when q[1]=1.
- Sample: MID + mag if positive, MID - mag if negative. With a 9-bit mag the result stays in 1..1023, so there is no clamp.
- FSM, where E0 is the edge at which IDLE, en=1 and tick=1 are all seen:
  - IDLE -> FETCH0 at E0: acc_i <= acc_i + step_i; rom_addr <= fold(acc0); sign0 latched; ph1 snapshot held.
  - FETCH0 -> FETCH1 at E1: rom_addr <= fold(ph1); sign1 latched. The ROM samples addr0 at this edge.
  - FETCH1 -> CAPT1 at E2: sample0 <= f(rom_data, sign0); valid[0] high during the following cycle.
  - CAPT1 -> IDLE at E3: sample1 <= f(rom_data, sign1); valid[1] high during the following cycle.
- Latency and throughput: sample0 updates 2 cycles after the tick edge, sample1 after 3. A tick every 4 cycles is sustained.
- Tick while busy: ignored. overrun <= 1. The running sequence is unaffected and no extra accumulator step occurs.
- en deasserted mid-sequence: the sequence completes; later ticks are ignored until en returns.
- Step values change only take effect at the next accepting edge.
- Accumulator wraps modulo 2^ACC_W with no flag.
- Reset mid-sequence wins over everything: all state returns to reset values and the partial sequence is discarded with no valid pulse.
- rom_addr holds its last value in IDLE.

Decomposition:
- Package sine_pkg holds:
  - state enum {IDLE, FETCH0, FETCH1, CAPT1}
  - MID constant
  - a fold function returning {sign, addr}
  - a reconstruct function returning the sample from (mag, sign)
- Sub-module sine_phase_acc: one instance per channel. Inputs clk, reset, step, advance. Output phase, the pre-step value.

Test Plan:
All scenarios use a bench ROM model with one-cycle registered latency and rom_data = 4*addr.
- Reset: assert reset for 2 cycles mid-sequence -> sample0/1 = 512, valid = 0, busy = 0, overrun = 0, rom_addr = 0.
- Quarter steps on channel 0: step0 = 0x4000; ticks every 8 cycles -> sample0 sequence 512, 1020, 512, 4, 512. rom_addr sequence 0, 127, 0, 127.
- Channel 1 independence: step1 = 0x0080, step0 = 0 -> sample1 = 512 then 516, 520. valid[1] fires one cycle after valid[0] on each tick; sample0 stays 512.
- Overrun: tick at E0, then again at E0+1 -> overrun = 1, exactly one valid[0] and one valid[1]. acc0 advances once, so a step0 = 0x4000 next tick yields 1020.
- Wrap and back-to-back: step0 = 0xC000, ticks every 4 cycles for 8 ticks -> q sequence 0, 3, 2, 1, 0 with no stalls; overrun stays 0.
- Enable gating: en = 0 with tick pulses -> busy never rises, samples unchanged. Dropping en at E1 still completes both captures.
